fpm_arbiter: RTL

FPM_ARBITER -- requirements
Module: fpm_arbiter

---
 rtl/fpm_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fpm_arbiter.sv
// fpm_arbiter: round-robin front end that shares one combinational
// IEEE-754 single-precision multiplier between two requesters.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0_valid/a/b/ready      requester 0 operand pair handshake
//   req1_valid/a/b/ready      requester 1 operand pair handshake
//   res_valid/data/id/ready   result handshake; res_id names the owner
//   busy                      high whenever an operation is in flight
//   op_count                  completed operations, wraps at 16 bits
//
// State table
//   IDLE | waiting for a valid requester; ready offered to the grantee
//   EXEC | operands held on the multiplier for EXEC_CYCLES cycles
//   DONE | result presented until the consumer accepts it

module fpm_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_id,
  input  logic        res_ready,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] op_a, op_b, fpm_out;
  logic [3:0]  exec_cnt;
  logic        owner, last_grant, grant, any_valid;
  logic        accept, exec_last, res_fire;

  fpm u_fpm (
    .Num1      (op_a),
    .Num2      (op_b),
    .final_res (fpm_out)
  );

  // On a tie the grant goes to whoever did not win last time.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;

  // Ready is gated by rst so nothing is offered while reset is held.
  assign accept     = (state == IDLE) & any_valid & ~rst;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  assign exec_last = (state == EXEC) && (exec_cnt == EXEC_LAST);
  assign res_fire  = (state == DONE) & res_ready;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (exec_last) state_nxt = DONE;
      DONE:    if (res_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      exec_cnt   <= '0;
      res_data   <= '0;
      res_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
        owner      <= grant;
        last_grant <= grant;
        exec_cnt   <= '0;
      end else if ((state == EXEC) && !exec_last) begin
        exec_cnt <= exec_cnt + 4'd1;
      end
      if (exec_last) begin
        res_data <= fpm_out;
        res_id   <= owner;
      end
      if (res_fire) op_count <= op_count + 16'd1;
    end
  end

endmodule

// fpm: combinational IEEE-754 single-precision multiply, round to nearest
// even. Subnormal inputs and underflowing results are flushed to signed
// zero; overflow saturates to signed infinity; any NaN or inf*0 gives the
// canonical quiet NaN.
//
// Ports
//   Num1, Num2   operands
//   final_res    product
module fpm (
  input  logic [31:0] Num1,
  input  logic [31:0] Num2,
  output logic [31:0] final_res
);

  logic              sign;
  logic [7:0]        e1, e2;
  logic [22:0]       f1, f2;
  logic              nan_in, inf_in, zero_in;
  logic [47:0]       ma, mb, prod;
  logic [23:0]       sig, sig_f;
  logic [24:0]       sig_r;
  logic              rnd_bit, sticky, rnd_up;
  logic signed [9:0] exp_n, exp_r;

  assign sign = Num1[31] ^ Num2[31];
  assign e1   = Num1[30:23];
  assign e2   = Num2[30:23];
  assign f1   = Num1[22:0];
  assign f2   = Num2[22:0];

  assign nan_in  = ((e1 == 8'hFF) && (f1 != '0)) || ((e2 == 8'hFF) && (f2 != '0));
  assign inf_in  = (e1 == 8'hFF) || (e2 == 8'hFF);
  assign zero_in = (e1 == 8'h00) || (e2 == 8'h00);

  always_comb begin
    ma   = {24'b0, 1'b1, f1};
    mb   = {24'b0, 1'b1, f2};
    prod = ma * mb;

    // Significand product lies in [1,4); normalise to 24 bits.
    if (prod[47]) begin
      sig     = prod[47:24];
      rnd_bit = prod[23];
      sticky  = |prod[22:0];
    end else begin
      sig     = prod[46:23];
      rnd_bit = prod[22];
      sticky  = |prod[21:0];
    end

    exp_n  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127
             + $signed({9'b0, prod[47]});
    rnd_up = rnd_bit & (sticky | sig[0]);
    sig_r  = {1'b0, sig} + {24'b0, rnd_up};

    if (sig_r[24]) begin
      sig_f = sig_r[24:1];
      exp_r = exp_n + 10'sd1;
    end else begin
      sig_f = sig_r[23:0];
      exp_r = exp_n;
    end

    final_res = {sign, exp_r[7:0], sig_f[22:0]};
    if (nan_in || (inf_in && zero_in)) final_res = 32'h7FC0_0000;
    else if (inf_in)                   final_res = {sign, 8'hFF, 23'b0};
    else if (zero_in)                  final_res = {sign, 31'b0};
    else if (exp_r >= 10'sd255)        final_res = {sign, 8'hFF, 23'b0};
    else if (exp_r <= 10'sd0)          final_res = {sign, 31'b0};
  end

endmodule
